// File: rtl/ins_prefetch.sv
// Sequential-PC instruction prefetcher: ROM req/gnt + in-order rvalid into a DEPTH-entry {pc,inst} FIFO.
// Head visible two cycles after request on a zero-wait ROM; requests stop when occupancy plus in-flight reaches DEPTH.
module ins_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic [31:0] pc_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] occ, out, disc;
  logic [CW:0]   used;
  logic          gnt, push, pop;

  // Credits come back only at the edge after a pop, never combinationally.
  assign used      = {1'b0, occ} + {1'b0, out};
  assign rom_req_o = ~rst & (used < (CW+1)'(DEPTH));
  assign rom_addr_o = fetch_pc;
  assign gnt  = rom_req_o & rom_gnt_i;
  assign push = rom_rvalid_i & ~jump_en_i & (disc == '0);
  assign pop  = (occ != '0) & ~hold_flag_i & ~jump_en_i;

  assign inst_valid_o = (occ != '0);
  assign pc_addr_o    = inst_valid_o ? fifo_pc[rd_ptr]   : 32'd0;
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      occ      <= '0;
      out      <= '0;
      disc     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      // The tag queue follows every ROM transaction, stale or not, so it is never flushed.
      if (gnt)          tag_wr <= tag_wr + PW'(1);
      if (rom_rvalid_i) tag_rd <= tag_rd + PW'(1);
      out <= out + CW'(gnt) - CW'(rom_rvalid_i);
      if (jump_en_i) begin
        fetch_pc <= jump_addr_i;
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // out already includes earlier stale requests, so everything still in flight is stale.
        disc     <= out + CW'(gnt) - CW'(rom_rvalid_i);
      end else begin
        if (gnt)                           fetch_pc <= fetch_pc + 32'd4;
        if (rom_rvalid_i && disc != '0)    disc <= disc - CW'(1);
        if (push)                          wr_ptr <= wr_ptr + PW'(1);
        if (pop)                           rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
      fifo_inst[wr_ptr] <= rom_rdata_i;
    end
  end
endmodule

// File: tb/tb_ins_prefetch.sv
// Directed bench for ins_prefetch: in-order ROM model with programmable latency, second instance with a wrapping RESET_PC.
module tb_ins_prefetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'd0;
  logic        hold = 1'b0;
  logic        rom_req, rom_gnt = 1'b1, rom_rvalid, inst_valid;
  logic [31:0] rom_addr, rom_rdata, pc_addr, inst;

  logic        j2 = 1'b0, h2 = 1'b0, gnt2 = 1'b1, rvalid2 = 1'b0;
  logic [31:0] ja2 = 32'd0, rdata2 = 32'd0;
  logic        req2, valid2;
  logic [31:0] addr2, pc2, inst2;

  int total = 0, bad = 0;
  int rom_lat = 1, grant_cnt, rcyc;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  ins_prefetch dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_flag_i(hold),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_gnt_i(rom_gnt), .rom_rvalid_i(rom_rvalid),
    .rom_rdata_i(rom_rdata), .pc_addr_o(pc_addr), .inst_o(inst), .inst_valid_o(inst_valid)
  );

  ins_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .jump_en_i(j2), .jump_addr_i(ja2), .hold_flag_i(h2),
    .rom_req_o(req2), .rom_addr_o(addr2), .rom_gnt_i(gnt2), .rom_rvalid_i(rvalid2),
    .rom_rdata_i(rdata2), .pc_addr_o(pc2), .inst_o(inst2), .inst_valid_o(valid2)
  );

  // In-order ROM: a grant at edge E returns addr^XK with rvalid sampled at edge E+rom_lat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      rom_rvalid <= 1'b0;
      rom_rdata  <= 32'd0;
      grant_cnt  <= 0;
      rcyc       <= 0;
    end else begin
      rcyc <= rcyc + 1;
      if (rom_req && rom_gnt) begin
        q_addr.push_back(rom_addr);
        q_due.push_back(rcyc + rom_lat - 1);
        grant_cnt <= grant_cnt + 1;
      end
      if (q_addr.size() > 0 && q_due[0] <= rcyc) begin
        rom_rvalid <= 1'b1;
        rom_rdata  <= q_addr.pop_front() ^ XK;
        void'(q_due.pop_front());
      end else begin
        rom_rvalid <= 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic h, input logic g);
    rst = 1'b1; jump_en = 1'b0; hold = h; rom_gnt = g; rom_lat = lat;
    step();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    step();
    check_val("rst_req", rom_req, 0);
    check_val("rst_addr", rom_addr, 32'h0);
    check_val("rst_valid", inst_valid, 0);
    check_val("rst_pc", pc_addr, 32'h0);
    check_val("rst_inst", inst, NOP);
    check_val("rst_addr2", addr2, 32'hFFFF_FFF8);
    check_val("rst_req2", req2, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait streaming; dut2 wraps past 2^32 and runs out of credits after four grants.
    for (int k = 0; k < 9; k++) begin
      step();
      check_val("seq_addr", rom_addr, 32'(4 * k));
      check_val("seq_req", rom_req, 1);
      check_val("seq_valid", inst_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        check_val("seq_pc", pc_addr, 32'(4 * (k - 2)));
        check_val("seq_inst", inst, 32'(4 * (k - 2)) ^ XK);
      end
      check_val("wrap_addr2", addr2, 32'hFFFF_FFF8 + 32'(4 * ((k < 4) ? k : 4)));
      check_val("wrap_req2", req2, (k < 4) ? 1 : 0);
    end

    // Jump coinciding with grant of 0x20 and the rvalid of 0x1C.
    jump_en = 1'b1; jump_addr = 32'h200;
    step();
    jump_en = 1'b0;
    check_val("jg_addr", rom_addr, 32'h200);
    check_val("jg_valid0", inst_valid, 0);
    check_val("jg_inst_nop", inst, NOP);
    step();
    check_val("jg_valid1", inst_valid, 0);
    check_val("jg_addr1", rom_addr, 32'h204);
    step();
    check_val("jg_valid2", inst_valid, 1);
    check_val("jg_pc", pc_addr, 32'h200);
    check_val("jg_inst", inst, 32'h200 ^ XK);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", inst_valid, 0);
    check_val("arst_pc", pc_addr, 32'h0);
    check_val("arst_inst", inst, NOP);
    check_val("arst_req", rom_req, 0);
    check_val("arst_addr", rom_addr, 32'h0);
    check_val("arst_addr2", addr2, 32'hFFFF_FFF8);

    // Hold from reset: four credits, then drain in order.
    do_reset(1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step();
    check_val("hold_req", rom_req, 0);
    check_val("hold_grants", 32'(grant_cnt), 32'd4);
    check_val("hold_valid", inst_valid, 1);
    check_val("hold_pc", pc_addr, 32'h0);
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_val("hold_pop_pc", pc_addr, 32'(4 * k));
      if (k == 1) begin
        check_val("hold_resume_req", rom_req, 1);
        check_val("hold_resume_addr", rom_addr, 32'd16);
      end
    end

    // 3-cycle ROM, two outstanding, jump to 0x100.
    do_reset(3, 1'b0, 1'b0);
    step();
    rom_gnt = 1'b1;
    step();
    step();
    rom_gnt = 1'b0;
    check_val("j3_grants", 32'(grant_cnt), 32'd2);
    check_val("j3_addr_pre", rom_addr, 32'h8);
    jump_en = 1'b1; jump_addr = 32'h100;
    step();
    jump_en = 1'b0; rom_gnt = 1'b1;
    check_val("j3_addr", rom_addr, 32'h100);
    check_val("j3_valid_a", inst_valid, 0);
    step();
    check_val("j3_addr_next", rom_addr, 32'h104);
    for (int k = 0; k < 3; k++) begin
      check_val("j3_no_stale", inst_valid, 0);
      step();
    end
    check_val("j3_valid", inst_valid, 1);
    check_val("j3_pc", pc_addr, 32'h100);
    check_val("j3_inst", inst, 32'h100 ^ XK);
    step();
    check_val("j3_pc2", pc_addr, 32'h104);

    // Grant withheld for five cycles.
    do_reset(1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    check_val("ng_addr_pre", rom_addr, 32'd12);
    check_val("ng_pc_pre", pc_addr, 32'd4);
    rom_gnt = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      step();
      check_val("ng_addr_stable", rom_addr, 32'd12);
      if (k == 4) begin
        check_val("ng_pc_last", pc_addr, 32'd8);
      end else begin
        check_val("ng_valid", inst_valid, 0);
        check_val("ng_inst", inst, NOP);
        check_val("ng_pc", pc_addr, 32'd0);
      end
    end
    rom_gnt = 1'b1;
    step();
    check_val("ng_resume_addr", rom_addr, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
